time_set_ctrl: RTL

Control stage that sits directly upstream of the 24-hour counter and minute counter in the clock datapath. It generates the 1 Hz count-enable that drives the seconds/minutes chain. It debounces the two front-panel buttons, runs the RUN / SET_HOUR / SET_MIN mode FSM, and emits single-cycle increment pulses (with auto-repeat) that connect to the counters' inc inputs. It also provides a blink flag for the display stage.

---
 rtl/time_set_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
//------------------------------------------------------------------------------
// time_set_ctrl : 1 Hz enable, button debounce, RUN/SET_HOUR/SET_MIN mode FSM,
//                 auto-repeating counter increments and display blink gate.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module time_set_ctrl #(
  parameter int SEC_DIV     = 50000000,
  parameter int DEB_CYCLES  = 1000000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int RPT_CYCLES  = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_set,
  output logic       en1hz,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int PW   = $clog2(SEC_DIV);
  localparam int BDIV = SEC_DIV / 4;
  localparam int BW   = (BDIV > 1) ? $clog2(BDIV) : 1;
  localparam int DW   = $clog2(DEB_CYCLES);
  localparam int RMAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [PW-1:0] c_pre_max  = PW'(SEC_DIV - 1);
  localparam logic [BW-1:0] c_blk_max  = BW'(BDIV - 1);
  localparam logic [DW-1:0] c_deb_max  = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] c_hold_max = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] c_rpt_max  = RW'(RPT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_SET_HOUR = 2'b01,
    S_SET_MIN  = 2'b10
  } state_t;

  state_t        r_state;
  logic [1:0]    w_raw;
  logic [1:0]    w_deb;
  logic [1:0]    r_deb_d;
  logic          w_mode_press;
  logic          w_set_press;
  logic [PW-1:0] r_pre;
  logic [BW-1:0] r_blk;
  logic [RW-1:0] r_rpt;
  logic          r_rpt_on;
  logic          r_rpt_hold;

  assign w_raw = {btn_set, btn_mode};

  // Index 0 is the mode button, index 1 the set button.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic          r_s1;
    logic          r_s2;
    logic          r_lvl;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_lvl <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_raw[i];
        r_s2 <= r_s1;
        if (r_s2 == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == c_deb_max) begin
          r_cnt <= '0;
          r_lvl <= r_s2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_deb[i] = r_lvl;
  end

  assign w_mode_press = w_deb[0] & ~r_deb_d[0];
  assign w_set_press  = w_deb[1] & ~r_deb_d[1];
  assign mode         = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_deb_d    <= '0;
      en1hz      <= 1'b0;
      inc_hour   <= 1'b0;
      inc_min    <= 1'b0;
      sec_clr    <= 1'b0;
      blink      <= 1'b1;
      r_pre      <= '0;
      r_blk      <= '0;
      r_rpt      <= '0;
      r_rpt_on   <= 1'b0;
      r_rpt_hold <= 1'b0;
    end else begin
      r_deb_d  <= w_deb;
      en1hz    <= 1'b0;
      inc_hour <= 1'b0;
      inc_min  <= 1'b0;
      sec_clr  <= 1'b0;
      if (w_mode_press) begin
        // A mode press always wins: no increment, repeat cancelled, counters restart.
        r_pre      <= '0;
        r_blk      <= '0;
        r_rpt      <= '0;
        r_rpt_on   <= 1'b0;
        r_rpt_hold <= 1'b0;
        case (r_state)
          S_RUN: begin
            r_state <= S_SET_HOUR;
            blink   <= 1'b0;
          end
          S_SET_HOUR: begin
            r_state <= S_SET_MIN;
            blink   <= 1'b0;
          end
          default: begin
            r_state <= S_RUN;
            blink   <= 1'b1;
            sec_clr <= 1'b1;
          end
        endcase
      end else if (r_state == S_RUN) begin
        blink    <= 1'b1;
        r_blk    <= '0;
        r_rpt    <= '0;
        r_rpt_on <= 1'b0;
        if (r_pre == c_pre_max) begin
          r_pre <= '0;
          en1hz <= 1'b1;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end else begin
        r_pre <= '0;
        if (r_blk == c_blk_max) begin
          r_blk <= '0;
          blink <= ~blink;
        end else begin
          r_blk <= r_blk + 1'b1;
        end
        if (w_set_press) begin
          r_rpt_on   <= 1'b1;
          r_rpt_hold <= 1'b1;
          r_rpt      <= '0;
          inc_hour   <= (r_state == S_SET_HOUR);
          inc_min    <= (r_state == S_SET_MIN);
        end else if (r_rpt_on && w_deb[1]) begin
          // First interval is the hold delay, later ones the repeat period.
          if (r_rpt == (r_rpt_hold ? c_hold_max : c_rpt_max)) begin
            r_rpt      <= '0;
            r_rpt_hold <= 1'b0;
            inc_hour   <= (r_state == S_SET_HOUR);
            inc_min    <= (r_state == S_SET_MIN);
          end else begin
            r_rpt <= r_rpt + 1'b1;
          end
        end else begin
          r_rpt_on <= 1'b0;
          r_rpt    <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire
